// File: rtl/stimulus_pkg.sv
// Shared types for the stimulus sequencer: decoded event record, run-state
// encoding and the default timestamp width.
package stimulus_pkg;

    localparam int DEFAULT_TIME_W = 16;

    // Decoded event fields are held at fixed maximum widths; the FIFO itself
    // stores only the bits the instance parameters need.
    localparam int EV_TIME_W = 32;
    localparam int EV_ROW_W  = 8;

    typedef struct packed {
        logic [EV_TIME_W-1:0] ev_time;
        logic [EV_ROW_W-1:0]  row;
        logic [7:0]           address;
        logic                 on_off;
    } stim_event_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/spike_if.sv
// One stimulus lane into the external spike router.
interface spike_if;
    logic       valid;
    logic       on_off;
    logic [7:0] address;

    modport master (output valid, on_off, address);
    modport slave  (input  valid, on_off, address);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; head data is read straight
// from storage, so a newly pushed entry is visible the cycle after the push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the counters alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/stimulus_sequencer.sv
// Time-scheduled spike source: buffers timestamped events and emits each one
// as a one-cycle pulse on its row once the run clock reaches its timestamp.
module stimulus_sequencer
    import stimulus_pkg::*;
#(
    parameter int NUM_SYNAPSE_ROWS = 1,
    parameter int FIFO_DEPTH       = 16,
    parameter int TIME_W           = DEFAULT_TIME_W,
    localparam int ROW_W = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [TIME_W-1:0] end_time,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [TIME_W-1:0] push_time,
    input  logic [ROW_W-1:0]  push_row,
    input  logic [7:0]        push_address,
    input  logic              push_on_off,
    spike_if.master           stim_out [NUM_SYNAPSE_ROWS],
    output logic              busy,
    output logic              done,
    output logic [LVL_W-1:0]  fill_level,
    output logic [15:0]       late_count,
    output logic              order_error,
    output logic              row_error
);

    localparam int FIFO_W = TIME_W + ROW_W + 9;

    seq_state_t                         state_q, state_d;
    logic [TIME_W-1:0]                  now_q, now_d;
    logic [TIME_W-1:0]                  last_time_q, last_time_d;
    logic [15:0]                        late_q, late_d;
    logic                               order_err_q, order_err_d;
    logic                               row_err_q, row_err_d;
    logic [NUM_SYNAPSE_ROWS-1:0]        out_valid_q, out_valid_d;
    logic [NUM_SYNAPSE_ROWS-1:0]        out_on_off_q, out_on_off_d;
    logic [NUM_SYNAPSE_ROWS-1:0][7:0]   out_addr_q, out_addr_d;

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;
    logic [LVL_W-1:0]  fifo_level;
    stim_event_t       head;
    logic              pop_en;
    logic              row_ok;

    assign fifo_push  = push_valid && !fifo_full;
    assign fifo_wdata = {push_time, push_row, push_address, push_on_off};

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop_en),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        head         = '0;
        head.ev_time = EV_TIME_W'(fifo_rdata[FIFO_W-1 -: TIME_W]);
        head.row     = EV_ROW_W'(fifo_rdata[9 +: ROW_W]);
        head.address = fifo_rdata[8:1];
        head.on_off  = fifo_rdata[0];
    end

    assign row_ok = (32'(head.row) < NUM_SYNAPSE_ROWS);

    // Run control: stop takes priority over both the end-time check and any pop.
    always_comb begin
        state_d = state_q;
        now_d   = now_q;
        pop_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    now_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    pop_en = !fifo_empty && (head.ev_time <= EV_TIME_W'(now_q));
                    if (now_q == end_time) begin
                        state_d = ST_DONE;
                    end else begin
                        now_d = now_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d  = '0;
        out_on_off_d = '0;
        out_addr_d   = '0;
        for (int unsigned r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            if (pop_en && row_ok && (32'(head.row) == r)) begin
                out_valid_d[r]  = 1'b1;
                out_on_off_d[r] = head.on_off;
                out_addr_d[r]   = head.address;
            end
        end

        late_d = late_q;
        if (pop_en && (head.ev_time < EV_TIME_W'(now_q)) && (late_q != '1)) begin
            late_d = late_q + 16'd1;
        end

        row_err_d   = row_err_q | (pop_en && !row_ok);
        order_err_d = order_err_q | (fifo_push && (push_time < last_time_q));
        last_time_d = fifo_push ? push_time : last_time_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            now_q        <= '0;
            last_time_q  <= '0;
            late_q       <= '0;
            order_err_q  <= 1'b0;
            row_err_q    <= 1'b0;
            out_valid_q  <= '0;
            out_on_off_q <= '0;
            out_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            now_q        <= now_d;
            last_time_q  <= last_time_d;
            late_q       <= late_d;
            order_err_q  <= order_err_d;
            row_err_q    <= row_err_d;
            out_valid_q  <= out_valid_d;
            out_on_off_q <= out_on_off_d;
            out_addr_q   <= out_addr_d;
        end
    end

    for (genvar g = 0; g < NUM_SYNAPSE_ROWS; g++) begin : g_stim
        assign stim_out[g].valid   = out_valid_q[g];
        assign stim_out[g].on_off  = out_on_off_q[g];
        assign stim_out[g].address = out_addr_q[g];
    end

    assign push_ready  = !fifo_full;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign fill_level  = fifo_level;
    assign late_count  = late_q;
    assign order_error = order_err_q;
    assign row_error   = row_err_q;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Bench for stimulus_sequencer (3 rows, 16-deep buffer): table vectors,
// directed multi-cycle sequences and random traffic against a queue model.
module tb_stimulus_sequencer;

    localparam int ROWS  = 3;
    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] end_time;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_time;
    logic [1:0]  push_row;
    logic [7:0]  push_address;
    logic        push_on_off;
    logic        busy;
    logic        done;
    logic [4:0]  fill_level;
    logic [15:0] late_count;
    logic        order_error;
    logic        row_error;

    logic [2:0]  obs_valid;
    logic [2:0]  obs_on;
    logic [23:0] obs_addr;

    spike_if stim_if [ROWS] ();

    stimulus_sequencer #(
        .NUM_SYNAPSE_ROWS (ROWS),
        .FIFO_DEPTH       (DEPTH),
        .TIME_W           (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .end_time     (end_time),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_time    (push_time),
        .push_row     (push_row),
        .push_address (push_address),
        .push_on_off  (push_on_off),
        .stim_out     (stim_if),
        .busy         (busy),
        .done         (done),
        .fill_level   (fill_level),
        .late_count   (late_count),
        .order_error  (order_error),
        .row_error    (row_error)
    );

    for (genvar g = 0; g < ROWS; g++) begin : g_obs
        assign obs_valid[g]       = stim_if[g].valid;
        assign obs_on[g]          = stim_if[g].on_off;
        assign obs_addr[g*8 +: 8] = stim_if[g].address;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending events as a plain queue, run clock as an int.
    typedef struct {
        int t;
        int row;
        int addr;
        bit on;
    } ev_t;

    ev_t      q[$];
    bit       m_run, m_done;
    int       m_now, m_late, m_last;
    bit       m_oerr, m_rerr;
    logic [2:0]  e_valid, e_on;
    logic [23:0] e_addr;

    task automatic model_edge();
        int   sz;
        bit   popping;
        ev_t  ev;
        if (reset) begin
            q.delete();
            m_run = 0; m_done = 0; m_now = 0; m_late = 0; m_last = 0;
            m_oerr = 0; m_rerr = 0;
            e_valid = '0; e_on = '0; e_addr = '0;
            return;
        end
        sz = q.size();
        e_valid = '0; e_on = '0; e_addr = '0;
        popping = m_run && !stop && sz > 0 && q[0].t <= m_now;
        if (popping) begin
            ev = q.pop_front();
            if (ev.t < m_now && m_late < 65535) m_late++;
            if (ev.row < ROWS) begin
                e_valid[ev.row]       = 1'b1;
                e_on[ev.row]          = ev.on;
                e_addr[ev.row*8 +: 8] = 8'(ev.addr);
            end else begin
                m_rerr = 1;
            end
        end
        if (push_valid && sz < DEPTH) begin
            if (int'(push_time) < m_last) m_oerr = 1;
            m_last = int'(push_time);
            ev.t = int'(push_time); ev.row = int'(push_row);
            ev.addr = int'(push_address); ev.on = push_on_off;
            q.push_back(ev);
        end
        if (m_run) begin
            if (stop) m_run = 0;
            else if (m_now == int'(end_time)) begin m_run = 0; m_done = 1; end
            else m_now++;
        end else if (start) begin
            m_run = 1; m_done = 0; m_now = 0;
        end
    endtask

    task automatic compare_model();
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("fill_level", fill_level, q.size());
        check("push_ready", push_ready, q.size() < DEPTH);
        check("late_count", late_count, m_late);
        check("order_error", order_error, m_oerr);
        check("row_error", row_error, m_rerr);
        check("stim_valid", obs_valid, e_valid);
        check("stim_on_off", obs_on, e_on);
        check("stim_address", obs_addr, e_addr);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    task automatic push_ev(input int t, input int row, input int addr, input bit on);
        push_valid = 1'b1; push_time = 16'(t); push_row = 2'(row);
        push_address = 8'(addr); push_on_off = on;
        cycle();
        push_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    int pk[3];
    int pa[3];
    int po[3];
    int npulse;

    // Observe n+1 cycles starting at the current one (k = 0) and note first pulse per row.
    task automatic run_watch(input int n);
        for (int r = 0; r < 3; r++) begin pk[r] = -1; pa[r] = 0; po[r] = 0; end
        npulse = 0;
        for (int k = 0; k <= n; k++) begin
            for (int r = 0; r < 3; r++) begin
                if (obs_valid[r]) begin
                    npulse++;
                    if (pk[r] < 0) begin
                        pk[r] = k; pa[r] = int'(obs_addr[r*8 +: 8]); po[r] = int'(obs_on[r]);
                    end
                end
            end
            if (k < n) cycle();
        end
    endtask

    typedef struct {
        int t;
        int row;
        int addr;
        bit on;
        int exp_k;
        bit exp_rerr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int dk;
        reset = 1'b0; start = 1'b0; stop = 1'b0; end_time = 16'd100;
        push_valid = 1'b0; push_time = '0; push_row = '0; push_address = '0; push_on_off = 1'b0;
        q.delete(); m_run = 0; m_done = 0; m_now = 0; m_late = 0; m_last = 0;
        m_oerr = 0; m_rerr = 0; e_valid = '0; e_on = '0; e_addr = '0;

        vecs[0] = '{t: 5,  row: 0, addr: 'h03, on: 1'b1, exp_k: 6,  exp_rerr: 1'b0};
        vecs[1] = '{t: 0,  row: 2, addr: 'hAA, on: 1'b0, exp_k: 1,  exp_rerr: 1'b0};
        vecs[2] = '{t: 12, row: 1, addr: 'h5C, on: 1'b1, exp_k: 13, exp_rerr: 1'b0};
        vecs[3] = '{t: 7,  row: 3, addr: 'h11, on: 1'b1, exp_k: -1, exp_rerr: 1'b1};

        do_reset();
        check("reset_busy", busy, 0);
        check("reset_fill", fill_level, 0);
        check("reset_ready", push_ready, 1);
        check("reset_valid", obs_valid, 0);

        // Single-event vectors: pulse lands one cycle after now reaches t.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            end_time = 16'd100;
            push_ev(vecs[i].t, vecs[i].row, vecs[i].addr, vecs[i].on);
            do_start();
            run_watch(20);
            check("vec_row_error", row_error, vecs[i].exp_rerr);
            check("vec_fill_after", fill_level, 0);
            check("vec_late", late_count, 0);
            if (vecs[i].exp_k < 0) begin
                check("vec_no_pulse", npulse, 0);
            end else begin
                check("vec_pulse_k", pk[vecs[i].row], vecs[i].exp_k);
                check("vec_pulse_count", npulse, 1);
                check("vec_addr", pa[vecs[i].row], vecs[i].addr);
                check("vec_on_off", po[vecs[i].row], vecs[i].on);
            end
        end

        // Two events at the same timestamp: second is emitted a cycle late.
        do_reset();
        push_ev(2, 0, 'h10, 1'b1);
        push_ev(2, 1, 'h20, 1'b1);
        do_start();
        run_watch(10);
        check("same_t_row0_k", pk[0], 3);
        check("same_t_row1_k", pk[1], 4);
        check("same_t_late", late_count, 1);

        // Fill to capacity, reject one more, then free one slot with a single pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_ev(0, 0, i, 1'b1);
        check("full_ready", push_ready, 0);
        check("full_level", fill_level, 16);
        push_ev(0, 0, 'hEE, 1'b1);
        check("full_extra_level", fill_level, 16);
        do_start();
        check("full_run_ready", push_ready, 0);
        cycle();
        check("after_pop_ready", push_ready, 1);
        check("after_pop_level", fill_level, 15);
        check("after_pop_pulse", obs_valid, 3'b001);
        stop = 1'b1; cycle(); stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_level", fill_level, 15);
        check("stop_valid", obs_valid, 0);

        // Out-of-order push: flag set, arrival order kept, second one late.
        do_reset();
        push_ev(10, 1, 'h01, 1'b1);
        push_ev(4, 2, 'h02, 1'b0);
        check("order_error", order_error, 1);
        do_start();
        run_watch(20);
        check("order_first_k", pk[1], 11);
        check("order_second_k", pk[2], 12);
        check("order_late", late_count, 1);

        // End of run with a future event still buffered.
        do_reset();
        end_time = 16'd8;
        push_ev(20, 0, 'h42, 1'b1);
        do_start();
        dk = -1;
        for (int k = 0; k <= 15; k++) begin
            if (done && dk < 0) dk = k;
            if (k < 15) cycle();
        end
        check("done_k", dk, 9);
        check("done_level", fill_level, 1);
        check("done_valid", obs_valid, 0);

        // Reset while a pop is due: nothing may come out afterwards.
        do_reset();
        end_time = 16'd100;
        push_ev(0, 0, 'h55, 1'b1);
        do_start();
        reset = 1'b1; cycle(); reset = 1'b0;
        check("midreset_valid", obs_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_level", fill_level, 0);
        cycle();
        check("midreset_valid_next", obs_valid, 0);

        // Push into an empty buffer mid-run, then start+stop together.
        do_reset();
        end_time = 16'd50;
        do_start();
        for (int k = 0; k < 4; k++) cycle();
        push_ev(0, 2, 'h77, 1'b1);
        check("bypass_none", obs_valid, 0);
        cycle();
        check("bypass_pulse", obs_valid, 3'b100);
        check("bypass_addr", obs_addr[23:16], 8'h77);
        check("bypass_late", late_count, 1);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        check("stop_wins", busy, 0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 299) == 0);
            push_valid   = ($urandom_range(0, 9) < 4);
            push_time    = 16'(m_now + $urandom_range(0, 20) - 4 < 0 ? 0 : m_now + $urandom_range(0, 20) - 4);
            push_row     = 2'($urandom_range(0, 3));
            push_address = 8'($urandom);
            push_on_off  = 1'($urandom);
            start        = ($urandom_range(0, 19) == 0);
            stop         = ($urandom_range(0, 59) == 0);
            if (start && !busy) end_time = 16'($urandom_range(5, 60));
            cycle();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; push_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
